// File: rtl/serial_code_lock_if.sv
// ---------------------------------------------------------------------------
// serial_code_lock_if
// Groups the key-entry inputs and lock status outputs of serial_code_lock.
//   in_valid   : in_bit is presented this cycle
//   in_bit     : serial code bit, MSB first
//   clr        : abort the current partial entry
//   prog_en    : load prog_code into the code register (only while unlocked)
//   prog_code  : new code value
//   unlock     : high while the lock is open
//   fail       : one-cycle pulse per mismatched entry
//   locked_out : high while entry is blocked after too many mismatches
//   tries      : current consecutive mismatch count
//   bit_cnt    : bits collected in the current entry
// master = key-entry / control side, slave = the lock itself.
// ---------------------------------------------------------------------------
interface serial_code_lock_if #(
    parameter int CODE_W    = 4,
    parameter int MAX_TRIES = 3
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int CNT_W   = $clog2(CODE_W + 1);

    logic                in_valid;
    logic                in_bit;
    logic                clr;
    logic                prog_en;
    logic [CODE_W-1:0]   prog_code;
    logic                unlock;
    logic                fail;
    logic                locked_out;
    logic [TRIES_W-1:0]  tries;
    logic [CNT_W-1:0]    bit_cnt;

    modport master (
        output in_valid, in_bit, clr, prog_en, prog_code,
        input  unlock, fail, locked_out, tries, bit_cnt
    );

    modport slave (
        input  in_valid, in_bit, clr, prog_en, prog_code,
        output unlock, fail, locked_out, tries, bit_cnt
    );
endinterface

// File: rtl/serial_code_lock.sv
// ---------------------------------------------------------------------------
// serial_code_lock
// Collects CODE_W serial bits (MSB first) and compares them with a
// programmable code register. A match opens the lock for OPEN_CYCLES cycles;
// MAX_TRIES consecutive mismatches block entry for LOCKOUT_CYCLES cycles.
// The code register can only be rewritten while the lock is open.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   s_if : serial_code_lock_if.slave (entry inputs, registered status outputs)
// ---------------------------------------------------------------------------
module serial_code_lock #(
    parameter int                CODE_W         = 4,
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = 4'b1011,
    parameter int                MAX_TRIES      = 3,
    parameter int                OPEN_CYCLES    = 8,
    parameter int                LOCKOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    serial_code_lock_if.slave  s_if
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int CNT_W   = $clog2(CODE_W + 1);
    localparam int TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    state_t              r_state,   w_state;
    logic [CODE_W-1:0]   r_code,    w_code;
    // Only the CODE_W-1 most recent bits need storing: the final bit of an
    // entry is compared straight from in_bit in the cycle it arrives.
    logic [CODE_W-2:0]   r_sr,      w_sr;
    logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt;
    logic [TRIES_W-1:0]  r_tries,   w_tries;
    logic                r_unlock,  w_unlock;
    logic                r_fail,    w_fail;
    logic                r_locked,  w_locked;
    logic [TMR_W-1:0]    r_timer,   w_timer;
    logic [CODE_W-1:0]   w_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_COLLECT;
            r_code    <= DEFAULT_CODE;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_tries   <= '0;
            r_unlock  <= 1'b0;
            r_fail    <= 1'b0;
            r_locked  <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state;
            r_code    <= w_code;
            r_sr      <= w_sr;
            r_bit_cnt <= w_bit_cnt;
            r_tries   <= w_tries;
            r_unlock  <= w_unlock;
            r_fail    <= w_fail;
            r_locked  <= w_locked;
            r_timer   <= w_timer;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_code    = r_code;
        w_sr      = r_sr;
        w_bit_cnt = r_bit_cnt;
        w_tries   = r_tries;
        w_unlock  = r_unlock;
        w_fail    = 1'b0;
        w_locked  = r_locked;
        w_timer   = r_timer;
        w_entry   = {r_sr, s_if.in_bit};

        case (r_state)
            ST_COLLECT: begin
                // clr has priority: a bit arriving with clr is discarded.
                if (s_if.clr) begin
                    w_bit_cnt = '0;
                    w_sr      = '0;
                end else if (s_if.in_valid) begin
                    w_sr = w_entry[CODE_W-2:0];
                    if (r_bit_cnt == CNT_W'(CODE_W - 1)) begin
                        w_bit_cnt = '0;
                        if (w_entry == r_code) begin
                            w_state  = ST_OPEN;
                            w_unlock = 1'b1;
                            w_tries  = '0;
                            w_timer  = TMR_W'(OPEN_CYCLES - 1);
                        end else if (r_tries == TRIES_W'(MAX_TRIES - 1)) begin
                            w_state  = ST_LOCKOUT;
                            w_fail   = 1'b1;
                            w_locked = 1'b1;
                            w_tries  = TRIES_W'(MAX_TRIES);
                            w_timer  = TMR_W'(LOCKOUT_CYCLES - 1);
                        end else begin
                            w_fail  = 1'b1;
                            w_tries = r_tries + TRIES_W'(1);
                        end
                    end else begin
                        w_bit_cnt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end

            ST_OPEN: begin
                // Reprogramming is independent of the open timer, so it is
                // honoured even in the final open cycle.
                if (s_if.prog_en) begin
                    w_code = s_if.prog_code;
                end
                if (r_timer == '0) begin
                    w_state  = ST_COLLECT;
                    w_unlock = 1'b0;
                end else begin
                    w_timer = r_timer - TMR_W'(1);
                end
            end

            ST_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state   = ST_COLLECT;
                    w_locked  = 1'b0;
                    w_tries   = '0;
                    w_bit_cnt = '0;
                end else begin
                    w_timer = r_timer - TMR_W'(1);
                end
            end

            default: begin
                w_state = ST_COLLECT;
            end
        endcase
    end

    assign s_if.unlock     = r_unlock;
    assign s_if.fail       = r_fail;
    assign s_if.locked_out = r_locked;
    assign s_if.tries      = r_tries;
    assign s_if.bit_cnt    = r_bit_cnt;

endmodule
